// File: rtl/mem_io_responder_pkg.sv
// Shared types, IO map and decode helper for the cpu memory/IO responder.
// Imported by the interface, the TX FIFO and the top.
package memio_pkg;

  localparam logic [17:0] IO_UART_ADDR = 18'h30000;
  localparam logic [17:0] IO_CLK_ADDR  = 18'h30004;
  localparam logic [1:0]  IO_TAG       = 2'b11;

  typedef logic [7:0] byte_t;

  function automatic logic is_io(input logic [17:0] addr);
    return addr[17:16] == IO_TAG;
  endfunction

endpackage

// File: rtl/mem_io_responder_if.sv
// cpu byte bus between cpu (master) and the memory/IO responder (slave).
// Read data and the TX back-pressure flag flow back to the cpu.
interface mem_io_responder_if;
  import memio_pkg::*;

  logic [31:0] mem_a;
  byte_t       mem_dout;
  logic        mem_wr;
  byte_t       mem_din;
  logic        io_buffer_full;

  modport master (
    output mem_a, mem_dout, mem_wr,
    input  mem_din, io_buffer_full
  );

  modport slave (
    input  mem_a, mem_dout, mem_wr,
    output mem_din, io_buffer_full
  );

endinterface

// File: rtl/mem_io_responder_tx_fifo.sv
// Synchronous UART TX FIFO; push while full is dropped by the FIFO.
// o_count_nxt is the occupancy after this cycle's push/pop.
module memio_tx_fifo
  import memio_pkg::*;
#(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  input  logic                i_push,
  input  byte_t               i_data,
  input  logic                i_pop,
  output byte_t               o_data,
  output logic                o_full,
  output logic                o_empty,
  output logic [DEPTH_LOG2:0] o_count_nxt
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  typedef logic [DEPTH_LOG2:0]   cnt_t;
  typedef logic [DEPTH_LOG2-1:0] ptr_t;

  byte_t r_mem [DEPTH];
  ptr_t  r_wr_ptr;
  ptr_t  r_rd_ptr;
  cnt_t  r_count;
  logic  w_push;
  logic  w_pop;

  assign o_full  = (r_count == cnt_t'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr];

  assign o_count_nxt = r_count + cnt_t'(w_push) - cnt_t'(w_pop);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + ptr_t'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + ptr_t'(1);
      r_count <= o_count_nxt;
    end
  end

  always_ff @(posedge clk_in) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/mem_io_responder.sv
// cpu memory/IO responder: byte RAM, UART TX/RX ports, program-stop strobe.
// MEMIO_CYCLE_COUNTER_EN adds the cycle counter/snapshot at 0x30004..7.
module mem_io_responder
  import memio_pkg::*;
#(
  parameter int RAM_ADDR_W    = 17,
  parameter int TX_DEPTH_LOG2 = 3,
  parameter int FULL_MARGIN   = 2
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  mem_io_responder_if.slave bus,
  output logic              tx_valid,
  output byte_t             tx_data,
  input  logic              tx_ready,
  input  logic              rx_valid,
  input  byte_t             rx_data,
  output logic              rx_pop,
  output logic              program_stop,
  output logic              tx_overflow
);

  localparam int RAM_BYTES = 1 << RAM_ADDR_W;
  localparam int DEPTH     = 1 << TX_DEPTH_LOG2;
  typedef logic [TX_DEPTH_LOG2:0] cnt_t;

  logic [17:0]           w_a;
  logic [RAM_ADDR_W-1:0] w_idx;
  logic                  w_io;
  logic                  w_rd;
  logic                  w_wr;
  logic                  w_uart;
  logic                  w_stop;
  logic                  w_unused;

  assign w_a      = bus.mem_a[17:0];
  assign w_idx    = bus.mem_a[RAM_ADDR_W-1:0];
  assign w_unused = ^bus.mem_a[31:18];
  assign w_io     = is_io(w_a);
  assign w_wr     = bus.mem_wr;
  assign w_rd     = !bus.mem_wr;
  assign w_uart   = w_io && (w_a == IO_UART_ADDR);
  assign w_stop   = w_wr && w_io && (w_a == IO_CLK_ADDR);

  byte_t r_ram [RAM_BYTES];
  byte_t r_ram_q;

  always_ff @(posedge clk_in) begin
    if (w_wr && !w_io) r_ram[w_idx] <= bus.mem_dout;
    if (w_rd)          r_ram_q <= r_ram[w_idx];
  end

`ifdef MEMIO_CYCLE_COUNTER_EN
  logic [31:0] r_cnt;
  logic [31:0] r_snap;
  logic        w_clk;

  assign w_clk = w_io && (w_a[17:2] == IO_CLK_ADDR[17:2]);

  // Reading byte 0 latches the snapshot so bytes 1..3 stay coherent.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_cnt  <= '0;
      r_snap <= '0;
    end else begin
      r_cnt <= r_cnt + 32'd1;
      if (w_rd && w_io && (w_a == IO_CLK_ADDR)) r_snap <= r_cnt;
    end
  end
`endif

  byte_t w_io_rd;

  always_comb begin
    w_io_rd = '0;
    unique case (1'b1)
      w_uart: w_io_rd = rx_valid ? rx_data : '0;
`ifdef MEMIO_CYCLE_COUNTER_EN
      w_clk: begin
        unique case (w_a[1:0])
          2'd0:    w_io_rd = r_cnt[7:0];
          2'd1:    w_io_rd = r_snap[15:8];
          2'd2:    w_io_rd = r_snap[23:16];
          default: w_io_rd = r_snap[31:24];
        endcase
      end
`endif
      default: ;
    endcase
  end

  logic  w_push;
  logic  w_pop;
  logic  w_full;
  logic  w_empty;
  byte_t w_push_data;
  cnt_t  w_cnt_nxt;

  assign w_push      = w_stop || (w_wr && w_uart && (bus.mem_dout != '0));
  assign w_push_data = w_stop ? '0 : bus.mem_dout;
  assign tx_valid    = !w_empty;
  assign w_pop       = tx_valid && tx_ready;

  memio_tx_fifo #(
    .DEPTH_LOG2 (TX_DEPTH_LOG2)
  ) u_tx_fifo (
    .clk_in      (clk_in),
    .rst_n_in    (rst_n_in),
    .i_push      (w_push),
    .i_data      (w_push_data),
    .i_pop       (w_pop),
    .o_data      (tx_data),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_count_nxt (w_cnt_nxt)
  );

  logic  r_sel_ram;
  byte_t r_io_q;
  logic  r_buf_full;
  logic  r_stop;
  logic  r_ovf;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_sel_ram  <= 1'b0;
      r_io_q     <= '0;
      r_buf_full <= 1'b0;
      r_stop     <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      if (w_rd) begin
        r_sel_ram <= !w_io;
        r_io_q    <= w_io_rd;
      end
      r_buf_full <= (DEPTH - int'(w_cnt_nxt)) < FULL_MARGIN;
      if (w_stop)           r_stop <= 1'b1;
      if (w_push && w_full) r_ovf  <= 1'b1;
    end
  end

  assign bus.mem_din        = r_sel_ram ? r_ram_q : r_io_q;
  assign bus.io_buffer_full = r_buf_full;
  assign program_stop       = r_stop;
  assign tx_overflow        = r_ovf;
  assign rx_pop             = rst_n_in && w_rd && w_uart && rx_valid;

endmodule

// File: tb/tb_mem_io_responder.sv
// Scoreboard bench for mem_io_responder: directed bus/UART traffic,
// expected read bytes and TX bytes queued at issue, checked by a monitor.
module tb_mem_io_responder;
  import memio_pkg::*;

`ifdef MEMIO_CYCLE_COUNTER_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic  clk = 1'b0;
  logic  rst_n = 1'b0;
  logic  tx_valid;
  byte_t tx_data;
  logic  tx_ready;
  logic  rx_valid;
  byte_t rx_data;
  logic  rx_pop;
  logic  program_stop;
  logic  tx_overflow;

  mem_io_responder_if bus();

  mem_io_responder dut (
    .clk_in       (clk),
    .rst_n_in     (rst_n),
    .bus          (bus),
    .tx_valid     (tx_valid),
    .tx_data      (tx_data),
    .tx_ready     (tx_ready),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_pop       (rx_pop),
    .program_stop (program_stop),
    .tx_overflow  (tx_overflow)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  byte_t       rd_q[$];
  byte_t       tx_q[$];
  logic        rd_chk = 1'b0;
  logic        rd_pend = 1'b0;
  logic [31:0] tb_cnt;
  logic [31:0] snap;

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", n, act, exp);
    end
  endtask

  always @(posedge clk or negedge rst_n)
    if (!rst_n) tb_cnt <= '0;
    else        tb_cnt <= tb_cnt + 32'd1;

  // Mid-cycle monitor: read results one cycle after issue, TX on handshake.
  always @(negedge clk) begin
    if (rd_pend) begin
      if (rd_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL rd_unexpected got=%0h", bus.mem_din);
      end else begin
        chk("mem_din", {24'h0, bus.mem_din}, {24'h0, rd_q.pop_front()});
      end
    end
    rd_pend = rst_n && rd_chk;
    if (rst_n && tx_valid && tx_ready) begin
      if (tx_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL tx_unexpected got=%0h", tx_data);
      end else begin
        chk("tx_data", {24'h0, tx_data}, {24'h0, tx_q.pop_front()});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set(input logic [31:0] a, input logic w,
                     input byte_t d, input logic c);
    bus.mem_a    = a;
    bus.mem_wr   = w;
    bus.mem_dout = d;
    rd_chk       = c;
  endtask

  task automatic idle();
    step();
    set(32'h0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic wr(input logic [31:0] a, input byte_t d);
    step();
    set(a, 1'b1, d, 1'b0);
  endtask

  task automatic rd(input logic [31:0] a, input byte_t e);
    step();
    rd_q.push_back(e);
    set(a, 1'b0, 8'h00, 1'b1);
  endtask

  task automatic chk_all_zero(input string n);
    chk({n, "_din"},   {24'h0, bus.mem_din}, 32'h0);
    chk({n, "_txv"},   {31'h0, tx_valid}, 32'h0);
    chk({n, "_txd"},   {24'h0, tx_data}, 32'h0);
    chk({n, "_full"},  {31'h0, bus.io_buffer_full}, 32'h0);
    chk({n, "_rxpop"}, {31'h0, rx_pop}, 32'h0);
    chk({n, "_stop"},  {31'h0, program_stop}, 32'h0);
    chk({n, "_ovf"},   {31'h0, tx_overflow}, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    set(32'h0, 1'b0, 8'h00, 1'b0);
    tx_ready = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;

    // Cycle counter snapshot, little-endian bytes
    repeat (100) idle();
    step();
    snap = tb_cnt;
    rd_q.push_back(CNT_EN ? snap[7:0] : 8'h00);
    set(32'h30004, 1'b0, 8'h00, 1'b1);
    rd(32'h30005, CNT_EN ? snap[15:8] : 8'h00);
    rd(32'h30006, CNT_EN ? snap[23:16] : 8'h00);
    rd(32'h30007, CNT_EN ? snap[31:24] : 8'h00);
    idle();

    // RAM
    wr(32'h10, 8'hAB);
    rd(32'h10, 8'hAB);
    wr(32'h1FFFF, 8'h5C);
    wr(32'h0, 8'h11);
    rd(32'h1FFFF, 8'h5C);
    rd(32'h0, 8'h11);
    step();
    rd_q.push_back(8'h11);
    set(32'h20, 1'b1, 8'h77, 1'b1);
    rd(32'h20, 8'h77);
    wr(32'h30008, 8'h99);
    rd(32'h30008, 8'h00);
    idle();
    idle();

    // TX stream, zero byte ignored
    tx_ready = 1'b1;
    tx_q.push_back(8'h48);
    wr(32'h30000, 8'h48);
    tx_q.push_back(8'h69);
    wr(32'h30000, 8'h69);
    wr(32'h30000, 8'h00);
    repeat (5) idle();
    chk("tx_hi_left", tx_q.size(), 0);
    chk("tx_hi_idle", {31'h0, tx_valid}, 32'h0);

    // Fill, nearly-full flag, overflow, drain
    tx_ready = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tx_q.push_back(byte_t'(i));
      wr(32'h30000, byte_t'(i));
    end
    idle();
    chk("full_at6", {31'h0, bus.io_buffer_full}, 32'h0);
    tx_q.push_back(8'h07);
    wr(32'h30000, 8'h07);
    idle();
    chk("full_at7", {31'h0, bus.io_buffer_full}, 32'h1);
    tx_q.push_back(8'h08);
    wr(32'h30000, 8'h08);
    idle();
    chk("ovf_at8", {31'h0, tx_overflow}, 32'h0);
    wr(32'h30000, 8'h09);
    idle();
    chk("ovf_at9", {31'h0, tx_overflow}, 32'h1);
    tx_ready = 1'b1;
    repeat (12) idle();
    chk("drain_left", tx_q.size(), 0);
    chk("drain_full", {31'h0, bus.io_buffer_full}, 32'h0);
    chk("drain_txv", {31'h0, tx_valid}, 32'h0);

    // RX forwarding
    rx_valid = 1'b1;
    rx_data  = 8'h41;
    rd(32'h30000, 8'h41);
    #1;
    chk("rx_pop_hi", {31'h0, rx_pop}, 32'h1);
    idle();
    #1;
    chk("rx_pop_lo", {31'h0, rx_pop}, 32'h0);
    rx_valid = 1'b0;
    rd(32'h30000, 8'h00);
    #1;
    chk("rx_pop_none", {31'h0, rx_pop}, 32'h0);
    idle();

    // Program stop
    chk("stop_pre", {31'h0, program_stop}, 32'h0);
    tx_q.push_back(8'h00);
    wr(32'h30004, 8'h55);
    idle();
    chk("stop_set", {31'h0, program_stop}, 32'h1);
    repeat (4) idle();
    chk("stop_sticky", {31'h0, program_stop}, 32'h1);
    chk("stop_tx_left", tx_q.size(), 0);

    // Mid-stream reset with queued TX bytes and a read in flight
    tx_ready = 1'b0;
    wr(32'h30000, 8'h41);
    wr(32'h30000, 8'h42);
    wr(32'h30000, 8'h43);
    step();
    rx_valid = 1'b1;
    rx_data  = 8'h5A;
    set(32'h10, 1'b0, 8'h00, 1'b0);
    #2;
    rst_n = 1'b0;
    bus.mem_a = 32'h30000;
    #1;
    chk_all_zero("midrst");
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("midrst_hold");
    set(32'h0, 1'b0, 8'h00, 1'b0);
    rx_valid = 1'b0;
    rst_n    = 1'b1;
    tx_ready = 1'b1;
    repeat (5) idle();
    chk("post_rst_txv", {31'h0, tx_valid}, 32'h0);
    chk("post_rst_ovf", {31'h0, tx_overflow}, 32'h0);
    chk("rd_q_left", rd_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
